// File: rtl/dpll_freq_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpll_freq_lock_ctrl: windowed dco_out edge counter that steps the DCO     |
// | tuning index toward a target count and flags lock/rail conditions.        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module dpll_freq_lock_ctrl #(
  parameter int WINDOW     = 1024,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_WINS  = 4,
  parameter int INIT_TUNE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] target_cnt,
  input  logic [CNT_W-1:0] tol,
  input  logic             dco_out,
  output logic [7:0]       dco_code,
  output logic             dco_en,
  output logic             locked,
  output logic             railed,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count
);

  localparam int         WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int         SET_W    = $clog2(SETTLE_CYC + 1);
  localparam int         LK_W     = $clog2(LOCK_WINS + 1);
  localparam logic [3:0] TUNE_RST = 4'(INIT_TUNE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [3:0]         tune_q;
  logic               dco_q;
  logic [CNT_W-1:0]   edge_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [LK_W-1:0]    lock_cnt_q;
  logic               step_q;
  logic               dco_en_q;
  logic               locked_q;
  logic               railed_q;
  logic               meas_valid_q;
  logic [CNT_W-1:0]   meas_count_q;

  logic               rise;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W:0]     cnt_x;
  logic [CNT_W:0]     hi_b;
  logic [CNT_W:0]     lo_b;
  logic               in_band;
  logic               too_fast;
  logic               at_rail;
  logic [3:0]         tune_d;
  logic [LK_W-1:0]    lock_d;

  // Band arithmetic is one bit wider than the counter so target+tol never wraps.
  always_comb begin
    rise  = dco_out & ~dco_q;
    cnt_d = edge_cnt_q;
    if (rise && (edge_cnt_q != '1)) begin
      cnt_d = edge_cnt_q + CNT_W'(1);
    end
    cnt_x    = {1'b0, cnt_d};
    hi_b     = {1'b0, target_cnt} + {1'b0, tol};
    lo_b     = (tol > target_cnt) ? '0 : ({1'b0, target_cnt} - {1'b0, tol});
    in_band  = (cnt_x >= lo_b) && (cnt_x <= hi_b);
    too_fast = (cnt_x > hi_b);
    at_rail  = too_fast ? (tune_q == 4'hF) : (tune_q == 4'h0);
    tune_d   = too_fast ? (tune_q + 4'd1) : (tune_q - 4'd1);
    lock_d   = (lock_cnt_q == LK_W'(LOCK_WINS)) ? lock_cnt_q : (lock_cnt_q + LK_W'(1));
  end

  // The window verdict is registered on the last MEASURE edge so every
  // result is already visible on the outputs during the EVAL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tune_q       <= TUNE_RST;
      dco_q        <= 1'b0;
      edge_cnt_q   <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      lock_cnt_q   <= '0;
      step_q       <= 1'b0;
      dco_en_q     <= 1'b0;
      locked_q     <= 1'b0;
      railed_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
    end else begin
      dco_q        <= dco_out;
      meas_valid_q <= 1'b0;
      if (!start) begin
        state_q    <= IDLE;
        dco_en_q   <= 1'b0;
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
        railed_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= MEASURE;
            dco_en_q   <= 1'b1;
            edge_cnt_q <= '0;
            win_cnt_q  <= '0;
          end
          MEASURE: begin
            edge_cnt_q <= cnt_d;
            if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
              state_q      <= EVAL;
              meas_count_q <= cnt_d;
              meas_valid_q <= 1'b1;
              if (in_band) begin
                lock_cnt_q <= lock_d;
                locked_q   <= (lock_d == LK_W'(LOCK_WINS));
                railed_q   <= 1'b0;
                step_q     <= 1'b0;
              end else begin
                lock_cnt_q <= '0;
                locked_q   <= 1'b0;
                railed_q   <= at_rail;
                step_q     <= ~at_rail;
                if (!at_rail) begin
                  tune_q <= tune_d;
                end
              end
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
            end
          end
          EVAL: begin
            if (step_q) begin
              state_q      <= SETTLE;
              settle_cnt_q <= '0;
            end else begin
              state_q    <= MEASURE;
              edge_cnt_q <= '0;
              win_cnt_q  <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
              state_q    <= MEASURE;
              edge_cnt_q <= '0;
              win_cnt_q  <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + SET_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dco_code   = {tune_q, 4'b0001};
  assign dco_en     = dco_en_q;
  assign locked     = locked_q;
  assign railed     = railed_q;
  assign meas_valid = meas_valid_q;
  assign meas_count = meas_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dpll_freq_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dpll_freq_lock_ctrl: directed scoreboard bench for dpll_freq_lock_ctrl |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_dpll_freq_lock_ctrl;

  localparam int WIN = 200;
  localparam int SET = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] target_cnt = 12'd10;
  logic [11:0] tol = 12'd1;
  logic        dco_out = 1'b0;
  logic [7:0]  dco_code;
  logic        dco_en;
  logic        locked;
  logic        railed;
  logic        meas_valid;
  logic [11:0] meas_count;

  dpll_freq_lock_ctrl #(
    .WINDOW(WIN), .CNT_W(12), .SETTLE_CYC(SET), .LOCK_WINS(4), .INIT_TUNE(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_cnt(target_cnt), .tol(tol),
    .dco_out(dco_out), .dco_code(dco_code), .dco_en(dco_en), .locked(locked),
    .railed(railed), .meas_valid(meas_valid), .meas_count(meas_count)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int delta;
    int cnt;
    int lk;
    int code;
    int rl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ref_cyc = 0;

  // DCO stand-in: square wave of period per, or a constant level when tied.
  int per = 20;
  int ph = 0;
  bit restart = 1'b0;
  bit tie_en = 1'b0;
  bit tie_val = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    if (tie_en) begin
      dco_out = tie_val;
    end else begin
      if (restart) begin
        ph = per / 2;
        restart = 1'b0;
      end else begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
      end
      dco_out = (ph < per / 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input int lk, input int code, input int rl);
    exp_t e;
    e.delta = d;
    e.cnt   = c;
    e.lk    = lk;
    e.code  = code;
    e.rl    = rl;
    q.push_back(e);
  endtask

  task automatic wait_valids(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < n * 300) begin
      @(negedge clk);
      t++;
      if (meas_valid) got++;
    end
    if (got < n) chk("meas_valid_timeout", got, n);
  endtask

  // Monitor: every meas_valid pulse is matched against the next expectation.
  initial forever begin
    @(negedge clk);
    if (meas_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_meas_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("eval_cycle_delta", cyc - ref_cyc, e.delta);
        chk("meas_count", int'(meas_count), e.cnt);
        chk("locked", int'(locked), e.lk);
        chk("dco_code", int'(dco_code), e.code);
        chk("railed", int'(railed), e.rl);
      end
      ref_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dco_code", int'(dco_code), 'h81);
    chk("rst_dco_en", int'(dco_en), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_railed", int'(railed), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_meas_count", int'(meas_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lock: 10 edges per window, four in-band windows back to back.
    for (int i = 0; i < 4; i++) push(201, 10, (i == 3) ? 1 : 0, 'h81, 0);
    start = 1'b1;
    ref_cyc = cyc;
    @(negedge clk);
    chk("run_dco_en", int'(dco_en), 1);
    wait_valids(4);

    // Lock loss: 5 edges, tune steps down.
    per = 40; restart = 1'b1;
    push(201, 5, 0, 'h71, 0);
    wait_valids(1);

    // Too fast: 20 edges per window, climb to the rail at tune 15.
    per = 10; restart = 1'b1;
    push(201 + SET, 20, 0, 'h81, 0);
    for (int t = 9; t <= 15; t++) push(201 + SET, 20, 0, (t << 4) | 1, 0);
    push(201 + SET, 20, 0, 'hF1, 1);
    push(201, 20, 0, 'hF1, 1);
    wait_valids(10);

    // Slow back into band while railed.
    per = 20; restart = 1'b1;
    push(201, 10, 0, 'hF1, 0);
    wait_valids(1);

    // Stop mid-MEASURE: no result, tune retained.
    repeat (50) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("stop_dco_en", int'(dco_en), 0);
    chk("stop_locked", int'(locked), 0);
    chk("stop_dco_code", int'(dco_code), 'hF1);
    chk("stop_meas_valid", int'(meas_valid), 0);
    repeat (300) @(negedge clk);

    // Restart from retained tune 15, too slow, then reset mid-SETTLE.
    per = 40; restart = 1'b1;
    @(negedge clk);
    push(201, 5, 0, 'hE1, 0);
    start = 1'b1;
    ref_cyc = cyc;
    wait_valids(1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_dco_code", int'(dco_code), 'h81);
    chk("arst_dco_en", int'(dco_en), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_railed", int'(railed), 0);
    chk("arst_meas_valid", int'(meas_valid), 0);
    chk("arst_meas_count", int'(meas_count), 0);

    // Boundary: tol exceeds target with zero edges, then dco_out held high.
    tie_en = 1'b1; tie_val = 1'b0; dco_out = 1'b0;
    target_cnt = 12'd3; tol = 12'd5;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(201, 0, 0, 'h81, 0);
    start = 1'b1;
    ref_cyc = cyc;
    wait_valids(1);
    tie_val = 1'b1; dco_out = 1'b1;
    push(201, 0, 0, 'h81, 0);
    wait_valids(1);
    target_cnt = 12'd20; tol = 12'd5;
    push(201, 0, 0, 'h71, 0);
    wait_valids(1);

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpll_freq_lock_ctrl.md
Name: dpll_freq_lock_ctrl

Overview:
- Frequency-lock controller directly upstream of the DCO in the digital PLL.
- Counts dco_out rising edges over a fixed window of clk cycles and compares the count against a programmable target.
- Steps the DCO tuning word up or down until the count stays inside a tolerance band, then asserts locked.
- Drives the DCO's dco_code and en inputs; dco_out is fed back from the DCO and is synchronous to clk.

Parameters:
- WINDOW, 1024: measurement window length in clk cycles (>=2).
- CNT_W, 12: edge-counter width; must hold WINDOW/2.
- SETTLE_CYC, 64: wait cycles after a tuning change before the next measurement (>=1).
- LOCK_WINS, 4: consecutive in-band windows required to assert locked (>=1).
- INIT_TUNE, 8: reset/initial tuning index, 0..15.

Ports:
- clk  input  1  system clock (same clk as DCO)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level enable; high = run loop, low = stop
- target_cnt  input  CNT_W  desired dco_out rising edges per window
- tol  input  CNT_W  allowed +/- deviation from target_cnt
- dco_out  input  1  DCO output fed back
- dco_code  output  8  DCO code = {tune[3:0], 4'b0001}
- dco_en  output  1  DCO enable
- locked  output  1  frequency lock indicator
- railed  output  1  tune saturated at 0 or 15 while still out of band
- meas_valid  output  1  one-cycle pulse when meas_count updates
- meas_count  output  CNT_W  last completed window edge count

Behaviour:
- Reset values:
  - tune=INIT_TUNE, so dco_code={INIT_TUNE,4'b0001}.
  - dco_en=0, locked=0, railed=0, meas_valid=0, meas_count=0.
  - State=IDLE; internal counters and the edge-detect register are 0.
- Tune semantics: a higher tune gives a longer DCO period and a lower frequency.
  - Too many edges -> tune+1.
  - Too few edges -> tune-1.
  - Both directions saturate at 15 and 0.
- Edge detect: dco_q registers dco_out every cycle. A rising edge is dco_out=1 && dco_q=0. It is counted only in MEASURE. The count saturates at all-ones.
- States:
  - IDLE: dco_en=0. When start=1, go to MEASURE next cycle. dco_en=1 from that cycle on.
  - MEASURE: lasts exactly WINDOW cycles. The edge count is cleared on entry. Then go to EVAL.
  - EVAL: one cycle.
    - meas_count <= count; meas_valid=1 for this cycle only.
    - Band test uses CNT_W+1-bit arithmetic, so there is no wrap. The lower bound is clamped at 0.
    - In band (target-tol <= count <= target+tol):
      - lock_cnt increments, saturating at LOCK_WINS.
      - locked <= 1 when lock_cnt reaches LOCK_WINS in this EVAL.
      - railed <= 0. Tune is unchanged. Next state is MEASURE.
    - Out of band:
      - lock_cnt <= 0; locked <= 0 in the same EVAL.
      - Step tune as above.
      - If the step would pass 0 or 15: tune holds, railed <= 1, next state is MEASURE.
      - Otherwise railed <= 0 and next state is SETTLE.
  - SETTLE: SETTLE_CYC cycles with the edge counter idle and dco_en=1. This absorbs the DCO's period-update latency. Then go to MEASURE.
- start deassert in any state: next cycle go to IDLE.
  - dco_en=0, locked=0, lock_cnt=0, railed=0.
  - tune is retained. Any partial window is discarded with no meas_valid.
- start reasserted: the loop restarts from the retained tune.
- Latency: a window completes WINDOW+1 cycles after MEASURE entry, with meas_valid in the EVAL cycle. Outputs are registered.
- target_cnt and tol are sampled in EVAL only. Changing them mid-window is legal.
- Async reset mid-operation: all outputs return immediately to their reset values.

Test Plan:
- Lock: WINDOW=200, LOCK_WINS=4. Bench drives dco_out with a 20-cycle period; target_cnt=10, tol=1; start=1 at cycle 0.
  - Required: meas_valid at cycles 201, 402, 603, 804 with meas_count=10.
  - locked rises at cycle 804; dco_code stays 8'h81.
- Too fast: bench period 10 (20 edges/window), target 10, tol 1.
  - Required: first EVAL gives tune 9 (dco_code 8'h91), then SETTLE_CYC cycles, then MEASURE.
  - locked stays 0.
- Rail: INIT_TUNE=15, period 10, target 10.
  - Required: each EVAL gives railed=1; dco_code holds 8'hF1; no SETTLE is entered.
  - Then slow the bench to period 20: next EVAL gives railed=0.
- Lock loss: after lock, the bench changes the period to 40 (5 edges).
  - Required: locked=0 in the next EVAL cycle; tune decrements by 1.
- Stop/reset: deassert start mid-MEASURE -> next cycle IDLE, dco_en=0, no meas_valid, tune retained.
  - Pull rst_n low mid-SETTLE -> all outputs at reset values immediately, dco_code=8'h81.
- Boundary: tol >= target_cnt with 0 edges (dco_out tied 0) -> in band; no underflow false-out-of-band.
  - dco_out held 1 -> count 0.
